half_norm_round: RTL and testbench

HALF_NORM_ROUND -- requirements
Module: half_norm_round

---
 rtl/half_fp_pkg.sv | 22 ++
 rtl/half_round_rne.sv | 40 ++++
 rtl/half_norm_round.sv | 116 +++++++++++
 tb/tb_half_norm_round.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/half_fp_pkg.sv
// Shared constants, special encodings and FSM state type for the half-precision
// product normaliser/rounder.
package half_fp_pkg;

  localparam int BIAS_DEFAULT = 15;
  localparam int EXP_W        = 5;
  localparam int MANT_W       = 10;
  localparam int PROD_W       = 22;
  localparam int IN_EXP_W     = 7;
  localparam int E_W          = 8;

  localparam logic [EXP_W+MANT_W-1:0] INF_MAG  = 15'h7C00;
  localparam logic [EXP_W+MANT_W-1:0] ZERO_MAG = 15'h0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/half_round_rne.sv
// Round-to-nearest-even and IEEE half packing of a normalised 1.x product.
// Purely combinational; frac[20] is the hidden bit.
module half_round_rne
  import half_fp_pkg::*;
(
  input  logic                    sign,
  input  logic                    zero,
  input  logic signed [E_W-1:0]   exp_in,
  input  logic [PROD_W-2:0]       frac,
  input  logic                    sticky,
  output logic [15:0]             result
);

  logic [MANT_W-1:0]    mant;
  logic                 guard;
  logic                 stick;
  logic                 inc;
  logic [MANT_W:0]      mant_sum;
  logic signed [E_W:0]  exp_r;

  always_comb begin
    mant     = frac[19:10];
    guard    = frac[9];
    stick    = (|frac[8:0]) | sticky;
    inc      = guard & (stick | mant[0]);
    mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // A carry out leaves mant_sum[9:0] at zero, which is exactly the bumped significand.
    exp_r    = $signed({exp_in[E_W-1], exp_in}) + $signed({{E_W{1'b0}}, mant_sum[MANT_W]});

    // Zero/subnormal wins over overflow so that 0 * huge still flushes to zero.
    if (zero || !frac[20] || exp_r < 9'sd1) begin
      result = {sign, ZERO_MAG};
    end else if (exp_r >= 9'sd31) begin
      result = {sign, INF_MAG};
    end else begin
      result = {sign, exp_r[EXP_W-1:0], mant_sum[MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/half_norm_round.sv
// Normalises a raw 11x11-bit significand product one shift per cycle, then rounds
// and packs it to IEEE half; valid/ready handshake on both sides, one product in flight.
module half_norm_round
  import half_fp_pkg::*;
#(
  parameter int BIAS = BIAS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [IN_EXP_W-1:0] in_exp,
  input  logic [PROD_W-1:0]   in_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data
);

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [PROD_W-1:0]     frac_q, frac_d;
  logic signed [E_W-1:0] e_q, e_d;
  logic                  sticky_q, sticky_d;
  logic                  zero_q, zero_d;
  logic [15:0]           out_data_q, out_data_d;
  logic [15:0]           rounded;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      frac_q     <= '0;
      e_q        <= '0;
      sticky_q   <= 1'b0;
      zero_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      frac_q     <= frac_d;
      e_q        <= e_d;
      sticky_q   <= sticky_d;
      zero_q     <= zero_d;
      out_data_q <= out_data_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    frac_d     = frac_q;
    e_d        = e_q;
    sticky_d   = sticky_q;
    zero_d     = zero_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          frac_d   = in_frac;
          e_d      = $signed({1'b0, in_exp} - E_W'(BIAS));
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          state_d  = NORM;
        end
      end
      NORM: begin
        if (frac_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (frac_q[21]) begin
          frac_d   = frac_q >> 1;
          sticky_d = sticky_q | frac_q[0];
          e_d      = e_q + 8'sd1;
          state_d  = ROUND;
        end else if (!frac_q[20] && e_q > 8'sd1) begin
          frac_d = frac_q << 1;
          e_d    = e_q - 8'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_data_d = rounded;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_data = out_data_q;

  // Bit 21 is always clear once NORM hands over, so only the low 21 bits are rounded.
  half_round_rne u_round (
    .sign   (sign_q),
    .zero   (zero_q),
    .exp_in (e_q),
    .frac   (frac_q[PROD_W-2:0]),
    .sticky (sticky_q),
    .result (rounded)
  );

endmodule

// File: tb/tb_half_norm_round.sv
// Self-checking bench for half_norm_round: directed corner cases plus random
// products compared against a value-level normalise/round reference model.
module tb_half_norm_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total_checks;
  int failed_checks;

  half_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value-level model: locate the leading one, normalise in one step (left shift
  // limited by the exponent floor), then round the discarded tail to nearest even.
  function automatic logic [15:0] ref_model(input logic s, input logic [6:0] ex,
                                            input logic [21:0] fr, output int shifts);
    int          e;
    int          msb;
    int          keep;
    int          rem;
    logic        st;
    logic [21:0] f;
    e      = int'(ex) - 15;
    shifts = 0;
    if (fr == 22'd0) return {s, 15'h0000};
    msb = 0;
    for (int i = 0; i < 22; i++) if (fr[i]) msb = i;
    st = 1'b0;
    f  = fr;
    if (msb == 21) begin
      st = fr[0];
      f  = fr >> 1;
      e  = e + 1;
    end else begin
      shifts = 20 - msb;
      if (shifts > e - 1) shifts = (e - 1 > 0) ? e - 1 : 0;
      f = fr << shifts;
      e = e - shifts;
    end
    if (!f[20]) return {s, 15'h0000};
    keep = int'(f[20:10]);
    rem  = int'(f[9:0]);
    if (rem > 512 || (rem == 512 && (st || (keep % 2 == 1)))) keep = keep + 1;
    if (keep >= 2048) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e < 1)   return {s, 15'h0000};
    return {s, 5'(e), 10'(keep)};
  endfunction

  // Drives one product, counts edges to out_valid, optionally stalls in DONE.
  task automatic run_product(input string tag, input logic s, input logic [6:0] ex,
                             input logic [21:0] fr, input int hold);
    logic [15:0] exp_data;
    int          shifts;
    int          n;
    exp_data = ref_model(s, ex, fr, shifts);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = ex;
    in_frac  = fr;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom);
      in_frac  = 22'($urandom);
      in_exp   = 7'($urandom);
      in_sign  = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(2 + shifts));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_frac  = 22'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [21:0] a;
    logic [21:0] b;
    logic [21:0] fr;
    total_checks  = 0;
    failed_checks = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_frac   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    run_product("one",        1'b0, 7'd30, 22'h100000, 0);
    check("one_literal", 32'(out_data), 32'h3C00);
    run_product("one_p5sq",   1'b0, 7'd30, 22'h240000, 0);
    check("p5sq_literal", 32'(out_data), 32'h4080);
    run_product("quarter",    1'b0, 7'd30, 22'h040000, 0);
    check("quarter_literal", 32'(out_data), 32'h3400);
    run_product("tie_even",   1'b0, 7'd30, 22'h100200, 0);
    check("tie_even_literal", 32'(out_data), 32'h3C00);
    run_product("tie_odd",    1'b0, 7'd30, 22'h100600, 0);
    check("tie_odd_literal", 32'(out_data), 32'h3C02);
    run_product("overflow",   1'b1, 7'd60, 22'h100000, 0);
    check("overflow_literal", 32'(out_data), 32'hFC00);
    run_product("underflow",  1'b1, 7'd5,  22'h100000, 0);
    check("underflow_literal", 32'(out_data), 32'h8000);
    run_product("zero",       1'b1, 7'd30, 22'h000000, 0);
    check("zero_literal", 32'(out_data), 32'h8000);
    run_product("carry",      1'b0, 7'd30, 22'h1FFE00, 0);
    run_product("worst_lat",  1'b0, 7'd45, 22'h000001, 0);
    run_product("hold",       1'b0, 7'd30, 22'h180000, 5);

    // Reset in the middle of a long left-shift sequence.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 7'd30;
    in_frac  = 22'h000020;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    run_product("after_reset", 1'b0, 7'd30, 22'h100000, 0);
    check("after_reset_literal", 32'(out_data), 32'h3C00);

    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 3) begin
        fr = 22'($urandom);
      end else begin
        a  = 22'(1024 + $urandom_range(0, 1023));
        b  = 22'(1024 + $urandom_range(0, 1023));
        fr = a * b;
      end
      run_product("rand", 1'($urandom), 7'($urandom_range(0, 62)), fr, k % 5 == 0 ? 2 : 0);
    end

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
